// File: rtl/clk_freq_mon.sv
// Frequency monitor: counts rising edges of an asynchronous test clock over a
// fixed gate window of clk cycles, then reports the count, a tolerance check and overflow.
`timescale 1ns/1ps
module clk_freq_mon #(
    parameter int GATE_CYCLES = 50_000_000,
    parameter int CNT_WIDTH   = 32,
    parameter int SYNC_STAGES = 2
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 test_clk,
    input  logic                 start,
    input  logic                 continuous,
    input  logic [CNT_WIDTH-1:0] expected,
    input  logic [15:0]          tolerance,
    output logic                 busy,
    output logic [CNT_WIDTH-1:0] meas_cnt,
    output logic                 meas_valid,
    output logic                 freq_ok,
    output logic                 overflow
);

    localparam int GW = (GATE_CYCLES > 1) ? $clog2(GATE_CYCLES) : 1;
    localparam int DW = (CNT_WIDTH + 1 > 16) ? CNT_WIDTH + 1 : 16;
    localparam logic [GW-1:0] GATE_LAST = GW'(GATE_CYCLES - 1);

    typedef enum logic [1:0] {IDLE, ARM, MEAS, REPORT} state_e;

    state_e                 state_q, state_d;
    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic                   hist_q, hist_d;
    logic [GW-1:0]          gate_q, gate_d;
    logic [CNT_WIDTH-1:0]   cnt_q, cnt_d;
    logic                   sat_q, sat_d;
    logic [CNT_WIDTH-1:0]   res_cnt_q, res_cnt_d;
    logic                   res_ok_q, res_ok_d;
    logic                   res_ovf_q, res_ovf_d;

    logic                   edge_p;
    logic                   in_tol;
    logic [DW-1:0]          cnt_x, exp_x, tol_x, diff;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start) state_d = ARM;
            ARM:     state_d = MEAS;
            MEAS:    if (gate_q == GATE_LAST) state_d = REPORT;
            REPORT:  state_d = continuous ? ARM : IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Results are visible combinationally during REPORT so meas_valid and the data coincide.
    always_comb begin
        busy       = (state_q != IDLE);
        meas_valid = (state_q == REPORT);
        meas_cnt   = meas_valid ? cnt_q : res_cnt_q;
        overflow   = meas_valid ? sat_q : res_ovf_q;
        freq_ok    = meas_valid ? (!sat_q && in_tol) : res_ok_q;
    end

    always_comb begin
        sync_d = {sync_q[SYNC_STAGES-2:0], test_clk};
        hist_d = sync_q[SYNC_STAGES-1];
        edge_p = sync_q[SYNC_STAGES-1] & ~hist_q;
    end

    // Magnitude of the deviation, widened so neither the subtraction nor the tolerance wraps.
    always_comb begin
        cnt_x  = DW'(cnt_q);
        exp_x  = DW'(expected);
        tol_x  = DW'(tolerance);
        diff   = (cnt_x >= exp_x) ? (cnt_x - exp_x) : (exp_x - cnt_x);
        in_tol = (diff <= tol_x);
    end

    always_comb begin
        gate_d    = gate_q;
        cnt_d     = cnt_q;
        sat_d     = sat_q;
        res_cnt_d = res_cnt_q;
        res_ok_d  = res_ok_q;
        res_ovf_d = res_ovf_q;
        case (state_q)
            ARM: begin
                gate_d = '0;
                cnt_d  = '0;
                sat_d  = 1'b0;
            end
            MEAS: begin
                gate_d = gate_q + GW'(1);
                if (edge_p) begin
                    if (&cnt_q) sat_d = 1'b1;
                    else        cnt_d = cnt_q + CNT_WIDTH'(1);
                end
            end
            REPORT: begin
                res_cnt_d = cnt_q;
                res_ovf_d = sat_q;
                res_ok_d  = !sat_q && in_tol;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync_q    <= '0;
            hist_q    <= 1'b0;
            gate_q    <= '0;
            cnt_q     <= '0;
            sat_q     <= 1'b0;
            res_cnt_q <= '0;
            res_ok_q  <= 1'b0;
            res_ovf_q <= 1'b0;
        end else begin
            sync_q    <= sync_d;
            hist_q    <= hist_d;
            gate_q    <= gate_d;
            cnt_q     <= cnt_d;
            sat_q     <= sat_d;
            res_cnt_q <= res_cnt_d;
            res_ok_q  <= res_ok_d;
            res_ovf_q <= res_ovf_d;
        end
    end

endmodule

// File: tb/tb_clk_freq_mon.sv
// Self-checking bench for clk_freq_mon: a 32-bit instance for the main scenarios
// and a 4-bit instance for counter saturation, sharing one generated test clock.
`timescale 1ns/1ps
module tb_clk_freq_mon;

    localparam int G = 100;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        test_clk = 1'b0;
    logic        start = 1'b0;
    logic        continuous = 1'b0;
    logic [31:0] expected = '0;
    logic [15:0] tolerance = '0;
    logic        busy, meas_valid, freq_ok, overflow;
    logic [31:0] meas_cnt;

    logic        s_start = 1'b0;
    logic        s_cont = 1'b0;
    logic [3:0]  s_expected = '0;
    logic [15:0] s_tol = '0;
    logic        s_busy, s_valid, s_ok, s_ovf;
    logic [3:0]  s_cnt;

    int tper = 0;
    int n_cmp = 0;
    int n_fail = 0;

    clk_freq_mon #(.GATE_CYCLES(G), .CNT_WIDTH(32), .SYNC_STAGES(2)) u_dut (
        .clk(clk), .rst_n(rst_n), .test_clk(test_clk), .start(start),
        .continuous(continuous), .expected(expected), .tolerance(tolerance),
        .busy(busy), .meas_cnt(meas_cnt), .meas_valid(meas_valid),
        .freq_ok(freq_ok), .overflow(overflow)
    );

    clk_freq_mon #(.GATE_CYCLES(G), .CNT_WIDTH(4), .SYNC_STAGES(2)) u_sat (
        .clk(clk), .rst_n(rst_n), .test_clk(test_clk), .start(s_start),
        .continuous(s_cont), .expected(s_expected), .tolerance(s_tol),
        .busy(s_busy), .meas_cnt(s_cnt), .meas_valid(s_valid),
        .freq_ok(s_ok), .overflow(s_ovf)
    );

    initial forever #5 clk = ~clk;

    // Test clock period is tper clk cycles; edges sit 3 ns off clk edges to avoid races.
    initial forever begin
        if (tper == 0) begin
            test_clk = 1'b0;
            @(posedge clk);
            #3;
        end else begin
            test_clk = 1'b1;
            #(tper * 5);
            test_clk = 1'b0;
            #(tper * 5);
        end
    end

    task automatic set_period(input int p);
        tper = p;
        repeat (70 + $urandom_range(0, 9)) @(negedge clk);
    endtask

    task automatic run_single(output int lat);
        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0;
        lat = 1;
        do begin
            @(negedge clk);
            lat++;
        end while (!meas_valid && lat < 400);
    endtask

    task automatic wait_valid(output int lat);
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
        end while (!meas_valid && lat < 400);
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk);
        n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_busy got %b want 0", busy); end
        n_cmp++; if (meas_cnt !== 32'd0) begin n_fail++; $display("[TB] FAIL reset_cnt got %0d want 0", meas_cnt); end
        n_cmp++; if (meas_valid !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_valid got %b want 0", meas_valid); end
        n_cmp++; if (freq_ok !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_ok got %b want 0", freq_ok); end
        n_cmp++; if (overflow !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_ovf got %b want 0", overflow); end
        n_cmp++; if ({s_busy, s_cnt, s_valid, s_ok, s_ovf} !== 8'd0) begin n_fail++; $display("[TB] FAIL reset_sat_inst got %b want 0", {s_busy, s_cnt, s_valid, s_ok, s_ovf}); end
        rst_n = 1'b1;
    endtask

    task automatic test_basic();
        int lat;
        set_period(10);
        expected = 32'd10; tolerance = 16'd1;
        run_single(lat);
        n_cmp++; if (lat != G + 2) begin n_fail++; $display("[TB] FAIL basic_latency got %0d want %0d", lat, G + 2); end
        n_cmp++; if (meas_cnt < 9 || meas_cnt > 11) begin n_fail++; $display("[TB] FAIL basic_cnt got %0d want 9..11", meas_cnt); end
        n_cmp++; if (freq_ok !== 1'b1) begin n_fail++; $display("[TB] FAIL basic_ok got %b want 1", freq_ok); end
        n_cmp++; if (overflow !== 1'b0) begin n_fail++; $display("[TB] FAIL basic_ovf got %b want 0", overflow); end
        @(negedge clk);
        n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("[TB] FAIL basic_busy_after got %b want 0", busy); end
        n_cmp++; if (meas_valid !== 1'b0) begin n_fail++; $display("[TB] FAIL basic_valid_pulse got %b want 0", meas_valid); end
        n_cmp++; if (freq_ok !== 1'b1) begin n_fail++; $display("[TB] FAIL basic_ok_hold got %b want 1", freq_ok); end
    endtask

    task automatic test_mismatch();
        int lat;
        expected = 32'd20; tolerance = 16'd2;
        run_single(lat);
        n_cmp++; if (lat != G + 2) begin n_fail++; $display("[TB] FAIL mismatch_latency got %0d want %0d", lat, G + 2); end
        n_cmp++; if (meas_cnt < 9 || meas_cnt > 11) begin n_fail++; $display("[TB] FAIL mismatch_cnt got %0d want 9..11", meas_cnt); end
        n_cmp++; if (freq_ok !== 1'b0) begin n_fail++; $display("[TB] FAIL mismatch_ok got %b want 0", freq_ok); end
        n_cmp++; if (overflow !== 1'b0) begin n_fail++; $display("[TB] FAIL mismatch_ovf got %b want 0", overflow); end
    endtask

    task automatic test_zero();
        int lat;
        set_period(0);
        expected = 32'd0; tolerance = 16'd0;
        run_single(lat);
        n_cmp++; if (meas_cnt !== 32'd0) begin n_fail++; $display("[TB] FAIL zero_cnt got %0d want 0", meas_cnt); end
        n_cmp++; if (freq_ok !== 1'b1) begin n_fail++; $display("[TB] FAIL zero_ok got %b want 1", freq_ok); end
        expected = 32'd1;
        run_single(lat);
        n_cmp++; if (freq_ok !== 1'b0) begin n_fail++; $display("[TB] FAIL zero_ok_exp1 got %b want 0", freq_ok); end
    endtask

    task automatic test_saturation();
        int lat;
        set_period(4);
        s_expected = 4'd15; s_tol = 16'd15;
        @(negedge clk) s_start = 1'b1;
        @(negedge clk) s_start = 1'b0;
        lat = 1;
        do begin
            @(negedge clk);
            lat++;
        end while (!s_valid && lat < 400);
        n_cmp++; if (lat != G + 2) begin n_fail++; $display("[TB] FAIL sat_latency got %0d want %0d", lat, G + 2); end
        n_cmp++; if (s_cnt !== 4'd15) begin n_fail++; $display("[TB] FAIL sat_cnt got %0d want 15", s_cnt); end
        n_cmp++; if (s_ovf !== 1'b1) begin n_fail++; $display("[TB] FAIL sat_ovf got %b want 1", s_ovf); end
        n_cmp++; if (s_ok !== 1'b0) begin n_fail++; $display("[TB] FAIL sat_ok got %b want 0", s_ok); end
        @(negedge clk);
        n_cmp++; if (s_busy !== 1'b0) begin n_fail++; $display("[TB] FAIL sat_busy_after got %b want 0", s_busy); end
    endtask

    task automatic test_continuous();
        int lat;
        int pulses;
        set_period(20);
        expected = 32'd5; tolerance = 16'd1;
        continuous = 1'b1;
        run_single(lat);
        n_cmp++; if (lat != G + 2) begin n_fail++; $display("[TB] FAIL cont_first_latency got %0d want %0d", lat, G + 2); end
        n_cmp++; if (meas_cnt < 4 || meas_cnt > 6) begin n_fail++; $display("[TB] FAIL cont_first_cnt got %0d want 4..6", meas_cnt); end
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
            start = (lat == 30);
        end while (!meas_valid && lat < 400);
        start = 1'b0;
        n_cmp++; if (lat != G + 2) begin n_fail++; $display("[TB] FAIL cont_period_with_start got %0d want %0d", lat, G + 2); end
        n_cmp++; if (meas_cnt < 4 || meas_cnt > 6) begin n_fail++; $display("[TB] FAIL cont_second_cnt got %0d want 4..6", meas_cnt); end
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
            if (lat == 50) continuous = 1'b0;
        end while (!meas_valid && lat < 400);
        n_cmp++; if (lat != G + 2) begin n_fail++; $display("[TB] FAIL cont_last_period got %0d want %0d", lat, G + 2); end
        @(negedge clk);
        n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("[TB] FAIL cont_busy_after_stop got %b want 0", busy); end
        pulses = 0;
        repeat (150) begin
            @(negedge clk);
            if (meas_valid) pulses++;
        end
        n_cmp++; if (pulses != 0) begin n_fail++; $display("[TB] FAIL cont_extra_pulses got %0d want 0", pulses); end
    endtask

    task automatic test_reset_mid();
        int lat;
        int pulses;
        set_period(10);
        expected = 32'd10; tolerance = 16'd1;
        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0;
        repeat (51) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk) rst_n = 1'b1;
        n_cmp++; if ({busy, meas_valid, freq_ok, overflow} !== 4'd0) begin n_fail++; $display("[TB] FAIL midreset_flags got %b want 0000", {busy, meas_valid, freq_ok, overflow}); end
        n_cmp++; if (meas_cnt !== 32'd0) begin n_fail++; $display("[TB] FAIL midreset_cnt got %0d want 0", meas_cnt); end
        pulses = 0;
        repeat (200) begin
            @(negedge clk);
            if (meas_valid || busy) pulses++;
        end
        n_cmp++; if (pulses != 0) begin n_fail++; $display("[TB] FAIL midreset_activity got %0d want 0", pulses); end
        run_single(lat);
        n_cmp++; if (lat != G + 2) begin n_fail++; $display("[TB] FAIL midreset_restart_latency got %0d want %0d", lat, G + 2); end
        n_cmp++; if (meas_cnt < 9 || meas_cnt > 11) begin n_fail++; $display("[TB] FAIL midreset_restart_cnt got %0d want 9..11", meas_cnt); end
        n_cmp++; if (freq_ok !== 1'b1) begin n_fail++; $display("[TB] FAIL midreset_restart_ok got %b want 1", freq_ok); end
    endtask

    // Reference: edges in a G-cycle window of period p lie in floor..ceil of G/p, widened by one.
    task automatic test_random();
        int lat, p, lo, hi, dev;
        bit ok_exp;
        for (int i = 0; i < 6; i++) begin
            p = $urandom_range(3, 30);
            set_period(p);
            expected  = 32'($urandom_range(0, 40));
            tolerance = 16'($urandom_range(0, 3));
            lo = G / p - 1;
            hi = (G + p - 1) / p + 1;
            run_single(lat);
            dev = int'(meas_cnt) - int'(expected);
            if (dev < 0) dev = -dev;
            ok_exp = (dev <= int'(tolerance));
            n_cmp++; if (lat != G + 2) begin n_fail++; $display("[TB] FAIL rand%0d_latency got %0d want %0d", i, lat, G + 2); end
            n_cmp++; if (int'(meas_cnt) < lo || int'(meas_cnt) > hi) begin n_fail++; $display("[TB] FAIL rand%0d_cnt p=%0d got %0d want %0d..%0d", i, p, meas_cnt, lo, hi); end
            n_cmp++; if (freq_ok !== ok_exp) begin n_fail++; $display("[TB] FAIL rand%0d_ok cnt=%0d exp=%0d tol=%0d got %b want %b", i, meas_cnt, expected, tolerance, freq_ok, ok_exp); end
            n_cmp++; if (overflow !== 1'b0) begin n_fail++; $display("[TB] FAIL rand%0d_ovf got %b want 0", i, overflow); end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_mismatch();
        test_zero();
        test_saturation();
        test_continuous();
        test_reset_mid();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
